// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit core and the baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    localparam logic LineIdle  = 1'b1;
    localparam logic LineStart = 1'b0;

    // Widest bit counter needed for the legal DATA_W range (5..16).
    localparam int unsigned MaxBitCntW = 4;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Valid/ready word handshake between a transmit data source and uart_tx_core.
interface uart_tx_core_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running divide-by-CLKS_PER_BIT counter with synchronous clear; tick marks the last
// cycle of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign tick_o = !clr_i && (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// Self-timed UART frame transmitter with valid/ready input.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned LSB_FIRST    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_core_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    localparam int unsigned BitW = cnt_width(DATA_W);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_W - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 16 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || LSB_FIRST > 1 || PARITY_ODD > 1)
    begin : g_bad_param
        $error("uart_tx_core: illegal parameter value");
    end

    tx_state_t         state_q, state_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_clr, bit_tick;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Holding the divider clear while idle makes every bit, start included, a full period.
    assign baud_clr = (state_q == StIdle);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (baud_clr),
        .tick_o (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.tx_valid) begin
                    state_d   = StStart;
                    bit_cnt_d = '0;
                    shreg_d   = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d     = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            StStart: begin
                if (bit_tick) state_d = StData;
            end
            StData: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shreg_d   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LastStop) begin
                        state_d = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is registered from the next state so tx changes on the same edge as state.
    always_comb begin
        tx_d = LineIdle;
        unique case (state_d)
            StStart: tx_d = LineStart;
            StData:  tx_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default: tx_d = LineIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= LineIdle;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign busy         = (state_q != StIdle);
    assign bus.tx_ready = (state_q == StIdle);
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter. It serialises one DATA_W-bit word per frame onto a single line as a start bit, data bits, an optional parity bit and one or two stop bits, and holds each bit for a programmable number of clocks. It replaces the fixed 8-bit load/shift register with a self-timed frame engine and a valid/ready input handshake. It sits between the transmit-side data source and the serial pin.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..16.
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2.
- STOP_BITS, 1, number of stop bits; 1 or 2 only.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit DATA_W-1 is sent first.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity. Takes effect only with UART_TX_PARITY_EN.

- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled only at acceptance.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  core can accept a word.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (start through last stop bit).

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- Acceptance: tx_valid && tx_ready at a rising edge. tx_data is latched into the shift register, the bit counter and baud counter clear, and the FSM goes to START.
- tx_ready is 1 only in IDLE. busy is the inverse of being in IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. Its terminal count is the bit tick, and the bit tick advances the bit/state.
- START: tx=0 for one bit time, then DATA.
- DATA: DATA_W bit times. Bits go out in the order set by LSB_FIRST. The bit counter width is $clog2(DATA_W). After the last data bit the FSM goes to PARITY if the macro is defined, otherwise to STOP.
- PARITY: one bit time. tx = ^data_latched ^ PARITY_ODD.
- STOP: tx=1 for STOP_BITS bit times, then IDLE.
- Back-to-back: if tx_valid is high on the edge the FSM returns to IDLE, the word is accepted one cycle later. This gives exactly one idle-high cycle between frames and never a glitch low.
- tx_data changes after acceptance have no effect on the frame in flight.
- tx_valid dropping mid-frame has no effect.
- Reset mid-frame aborts the frame immediately. tx=1 asynchronously; no partial stop bit is required.
- Reset values: tx=1, tx_ready=1, busy=0, state=IDLE, all counters 0.

## Timing
- tx is registered. Its first low appears in the cycle after the accepting edge.
- Every bit, including start, parity and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length is (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with the macro and 0 without.
- tx_ready rises on the edge that ends the last stop bit, and busy falls on the same edge.
- Accept-to-accept minimum period is frame length + 1 cycle.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in, one parity bit is inserted between data and stop, and PARITY_ODD selects its sense.
- UART_TX_PARITY_EN not defined: no PARITY state and no parity logic. DATA goes directly to STOP, and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the state enum typedef tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - localparam helpers for counter widths;
  - constants for line idle level (1) and start level (0).
- Sub-module uart_baud_gen provides the CLKS_PER_BIT divider with clear input and tick output. It is reusable by the receiver.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, no parity; send 0x55 → tx holds for 4 cycles each: 0, then 1,0,1,0,1,0,1,0, then stop 1. Frame is 40 cycles; busy is high for 40 cycles; tx_ready returns at cycle 40.
- Same config with LSB_FIRST=0; send 0x81 → data bits are 1,0,0,0,0,0,0,1. A 0x01 run instead sends 0,0,0,0,0,0,0,1.
- Macro defined, PARITY_ODD=0; send 0x07 → parity bit 1. With PARITY_ODD=1 the parity bit is 0. The frame is 44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2 with tx_valid held high for two words, 0xA3 then 0x3C → second start bit begins exactly 1 idle cycle after the 8-cycle stop period. No word is lost or duplicated.
- Assert rst_n low mid-DATA of 0xFF → tx=1, tx_ready=1 and busy=0 immediately. After release, send 0x00 → clean full frame.
- Hold tx_valid with changing tx_data during a frame → only the accepted word is serialised. tx_ready stays 0 until the frame ends.
